// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for synchronous_fifo: owns r_en and turns the FIFO's registered data_out into a valid/ready stream.
// Optional build macro FIFO_RD_STREAM_STATS_EN adds the 16-bit rd_count delivered-word counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  logic [DATA_WIDTH-1:0] skid_buf [0:2];
  logic [1:0]            wptr;
  logic [1:0]            rptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            fill;
  logic [1:0]            occ_next;

  function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
    next_ptr = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Space check counts the word already in flight, so a capture always has a free slot.
  assign fill       = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && (fill < 3'd3);

  assign m_valid  = (occ != 2'd0);
  assign pop      = m_valid && m_ready;
  assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};

  always_comb begin
    m_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (rptr == i[1:0]) m_data = skid_buf[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < 3; i++) skid_buf[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ_next;
      if (inflight) begin
        for (int i = 0; i < 3; i++) begin
          if (wptr == i[1:0]) skid_buf[i] <= fifo_data;
        end
        wptr <= next_ptr(wptr);
      end
      if (pop) rptr <= next_ptr(rptr);
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 16'h0000;
    end else if (pop) begin
      rd_count <= rd_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 8-deep FIFO model driving fifo_empty/fifo_data.
// Stats checks are built only when FIFO_RD_STREAM_STATS_EN is defined.
module tb_fifo_rd_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] rd_count;
`endif

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  int errors = 0;
  int checks = 0;

  logic [7:0] fq[$];
  logic [7:0] got[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         issues = 0;
  int         rd_on_empty = 0;

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference FIFO: registered data_out one cycle after an accepted read.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_data  <= 8'h00;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
      if (wr_en && fq.size() < 8) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
      end
      if (fifo_rd_en && !fifo_empty) issues++;
      if (fifo_rd_en && fifo_empty) rd_on_empty++;
    end
  end

  task automatic wait_got(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en: got %b expected 0", fifo_rd_en); end
  endtask

  task automatic test_single();
    int i0;
    got.delete(); got_cyc.delete();
    m_ready = 1'b1;
    i0 = issues;
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en_n: got %b expected 1", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n: got %b expected 0", m_valid); end
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en_n1: got %b expected 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n1: got %b expected 0", m_valid); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid_n2: got %b expected 1", m_valid); end
    checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data_n2: got %h expected a5", m_data); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n3: got %b expected 0", m_valid); end
    checks++; if (issues - i0 !== 1) begin errors++; $display("FAIL single_issue_count: got %0d expected 1", issues - i0); end
  endtask

  task automatic test_streaming();
    logic [7:0] w;
    int gaps;
    got.delete(); got_cyc.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_got(8, 40);
    repeat (3) @(negedge clk);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      w = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (w !== 8'(i + 1)) begin errors++; $display("FAIL stream_word%0d: got %h expected %h", i, w, 8'(i + 1)); end
    end
    gaps = 0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    checks++; if (gaps !== 0) begin errors++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
  endtask

  task automatic test_backpressure();
    int i0;
    int unstable;
    logic [7:0] w;
    got.delete(); got_cyc.delete();
    m_ready = 1'b0;
    i0 = issues;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (issues - i0 !== 3) begin errors++; $display("FAIL bp_issues: got %0d expected 3", issues - i0); end
    checks++; if (fq.size() !== 5) begin errors++; $display("FAIL bp_fifo_left: got %0d expected 5", fq.size()); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b expected 0", fifo_rd_en); end
    unstable = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid !== 1'b1 || m_data !== 8'h01) unstable++;
      @(negedge clk);
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", unstable); end
    for (int i = 0; i < 16; i++) begin
      m_ready = ~i[0];
      @(negedge clk);
    end
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      w = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (w !== 8'(i + 1)) begin errors++; $display("FAIL bp_word%0d: got %h expected %h", i, w, 8'(i + 1)); end
    end
  endtask

  task automatic test_empty_gap();
    logic [7:0] w;
    int bad_rd;
    got.delete(); got_cyc.delete();
    m_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'h10;
    @(negedge clk);
    wr_en = 1'b0;
    bad_rd = 0;
    repeat (4) begin
      @(negedge clk);
      if (fifo_empty === 1'b1 && fifo_rd_en !== 1'b0) bad_rd++;
    end
    wr_en = 1'b1; wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    wait_got(2, 20);
    repeat (2) @(negedge clk);
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL gap_rd_en_empty: got %0d expected 0", bad_rd); end
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL gap_count: got %0d expected 2", got.size()); end
    w = (got.size() > 0) ? got[0] : 8'hxx;
    checks++; if (w !== 8'h10) begin errors++; $display("FAIL gap_word0: got %h expected 10", w); end
    w = (got.size() > 1) ? got[1] : 8'hxx;
    checks++; if (w !== 8'h11) begin errors++; $display("FAIL gap_word1: got %h expected 11", w); end
    checks++; if (rd_on_empty !== 0) begin errors++; $display("FAIL rd_on_empty_total: got %0d expected 0", rd_on_empty); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] w;
    got.delete(); got_cyc.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h21 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== 8'h21) begin errors++; $display("FAIL mid_pre_data: got %h expected 21", m_data); end
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", m_valid); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", m_data); end
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    got.delete(); got_cyc.delete();
    wr_en = 1'b1; wr_data = 8'h30;
    @(negedge clk);
    wr_en = 1'b0;
    wait_got(1, 20);
    repeat (4) @(negedge clk);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL mid_post_count: got %0d expected 1", got.size()); end
    w = (got.size() > 0) ? got[0] : 8'hxx;
    checks++; if (w !== 8'h30) begin errors++; $display("FAIL mid_post_word: got %h expected 30", w); end
  endtask

`ifdef FIFO_RD_STREAM_STATS_EN
  task automatic test_stats();
    got.delete(); got_cyc.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_got(20, 60);
    repeat (3) @(negedge clk);
    checks++; if (rd_count !== 16'd20) begin errors++; $display("FAIL stats_count20: got %0d expected 20", rd_count); end
    force dut.rd_count = 16'hFFFF;
    #1;
    release dut.rd_count;
    @(negedge clk);
    checks++; if (rd_count !== 16'hFFFF) begin errors++; $display("FAIL stats_preload: got %h expected ffff", rd_count); end
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    wait_got(21, 20);
    repeat (2) @(negedge clk);
    checks++; if (rd_count !== 16'h0000) begin errors++; $display("FAIL stats_wrap: got %h expected 0000", rd_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_empty_gap();
    test_reset_midstream();
`ifdef FIFO_RD_STREAM_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
